// File: rtl/echo_effect.sv
// Single-clock audio echo: mixes each FIFO sample with a gain-scaled copy from a circular delay line.
// Define ECHO_FEEDBACK_EN to store the mixed output (recursive echo) instead of the dry input.
module echo_effect #(
    parameter int memory_d_width   = 16,
    parameter int delay_addr_width = 12,
    parameter int gain_width       = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [memory_d_width-1:0]   i_data,
    input  logic                        i_data_valid,
    output logic                        o_read_enable,
    output logic [memory_d_width-1:0]   o_data,
    output logic                        o_data_valid,
    input  logic [delay_addr_width-1:0] i_delay,
    input  logic [gain_width-1:0]       i_gain,
    input  logic                        i_bypass,
    output logic                        o_busy
);

    localparam int depth = 2 ** delay_addr_width;
    localparam int pw    = memory_d_width + gain_width + 1;

    typedef enum logic [2:0] {CLEAR, IDLE, READ, FETCH, MIX, WRITE} state_t;

    state_t                              state, next_state;
    logic        [delay_addr_width-1:0]  clr_addr;
    logic        [delay_addr_width-1:0]  wr_ptr;
    logic        [delay_addr_width-1:0]  delay_p0;
    logic        [gain_width-1:0]        gain_p0;
    logic                                bypass_p0;
    logic signed [memory_d_width-1:0]    x_p1;
    logic signed [memory_d_width-1:0]    d_p1;
    logic signed [memory_d_width-1:0]    y_p2;
    logic signed [memory_d_width-1:0]    store_data;
    logic signed [pw-1:0]                mix_sum;
    logic        [delay_addr_width-1:0]  rd_addr;
    logic                                mem_we;
    logic        [delay_addr_width-1:0]  mem_addr;
    logic signed [memory_d_width-1:0]    mem_wdata;
    logic signed [memory_d_width-1:0]    mem [depth];

    localparam logic signed [pw-1:0] sat_max = {{(pw-memory_d_width+1){1'b0}}, {(memory_d_width-1){1'b1}}};
    localparam logic signed [pw-1:0] sat_min = {{(pw-memory_d_width+1){1'b1}}, {(memory_d_width-1){1'b0}}};

    // Full-width product followed by an arithmetic shift, so negative echoes round toward -inf.
    function automatic logic signed [pw-1:0] scale(input logic signed [memory_d_width-1:0] d,
                                                   input logic [gain_width-1:0] g);
        logic signed [pw-1:0] prod;
        prod = pw'(d) * pw'($signed({1'b0, g}));
        return prod >>> gain_width;
    endfunction

    function automatic logic signed [memory_d_width-1:0] saturate(input logic signed [pw-1:0] v);
        logic signed [memory_d_width-1:0] r;
        if (v > sat_max)      r = sat_max[memory_d_width-1:0];
        else if (v < sat_min) r = sat_min[memory_d_width-1:0];
        else                  r = v[memory_d_width-1:0];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (clr_addr == delay_addr_width'(depth - 1)) next_state = IDLE;
            IDLE:    if (i_data_valid) next_state = READ;
            READ:    next_state = FETCH;
            FETCH:   next_state = MIX;
            MIX:     next_state = WRITE;
            WRITE:   next_state = IDLE;
            default: next_state = CLEAR;
        endcase
    end

    always_comb begin
        o_read_enable = 1'b0;
        o_data_valid  = 1'b0;
        o_busy        = (state != IDLE);
        mem_we        = 1'b0;
        mem_addr      = wr_ptr;
        mem_wdata     = store_data;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_addr;
                mem_wdata = '0;
            end
            READ:  o_read_enable = 1'b1;
            WRITE: begin
                o_data_valid = 1'b1;
                mem_we       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_addr <= '0;
            wr_ptr   <= '0;
        end else begin
            if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
            if (state == WRITE) wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Stage 0: controls latched on the pop so mid-sample changes wait for the next sample.
    always_ff @(posedge clk) begin
        if (state == READ) begin
            delay_p0  <= i_delay;
            gain_p0   <= i_gain;
            bypass_p0 <= i_bypass;
        end
    end

    // Stage 1: dry sample and delayed sample (delay 0 reads wr_ptr itself = full depth).
    assign rd_addr = wr_ptr - delay_p0;

    always_ff @(posedge clk) begin
        if (state == FETCH) x_p1 <= $signed(i_data);
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (state == FETCH) d_p1 <= mem[rd_addr];
    end

    // Stage 2: mix, saturate, register the output word.
    assign mix_sum = pw'(x_p1) + scale(d_p1, gain_p0);

    always_ff @(posedge clk) begin
        if (reset)             y_p2 <= '0;
        else if (state == MIX) y_p2 <= bypass_p0 ? x_p1 : saturate(mix_sum);
    end

    assign o_data = y_p2;

`ifdef ECHO_FEEDBACK_EN
    assign store_data = y_p2;
`else
    assign store_data = x_p1;
`endif

endmodule

// File: tb/tb_echo_effect.sv
// Self-checking bench for echo_effect (depth 16) against a sample-history reference model.
module tb_echo_effect;

    localparam int dw    = 16;
    localparam int aw    = 4;
    localparam int gw    = 8;
    localparam int depth = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [dw-1:0] i_data;
    logic          i_data_valid;
    logic          o_read_enable;
    logic [dw-1:0] o_data;
    logic          o_data_valid;
    logic [aw-1:0] i_delay;
    logic [gw-1:0] i_gain;
    logic          i_bypass;
    logic          o_busy;

    int errors = 0;
    int checks = 0;
    int hist[$];

    echo_effect #(.memory_d_width(dw), .delay_addr_width(aw), .gain_width(gw)) dut (
        .clk(clk), .reset(reset), .i_data(i_data), .i_data_valid(i_data_valid),
        .o_read_enable(o_read_enable), .o_data(o_data), .o_data_valid(o_data_valid),
        .i_delay(i_delay), .i_gain(i_gain), .i_bypass(i_bypass), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the k-th sample since reset echoes whatever was stored D samples earlier (0 before that).
    function automatic int ref_sample(input int x, input int dly, input int g, input bit byp);
        int k, dd, d, p, s, y;
        k  = hist.size();
        dd = (dly == 0) ? depth : dly;
        d  = (k >= dd) ? hist[k - dd] : 0;
        p  = (d * g) >>> gw;
        s  = x + p;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        y = byp ? x : s;
`ifdef ECHO_FEEDBACK_EN
        hist.push_back(y);
`else
        hist.push_back(x);
`endif
        return y;
    endfunction

    // Called at a negedge while the DUT idles; returns at the negedge of the following IDLE cycle.
    task automatic run_sample(input logic [15:0] data, input int dly, input int g, input bit byp);
        int exp;
        check("idle_busy", {31'b0, o_busy}, 32'd0);
        i_data_valid = 1'b1;
        i_delay      = aw'(dly);
        i_gain       = gw'(g);
        i_bypass     = byp;
        exp = ref_sample(int'($signed(data)), dly, g, byp);
        @(negedge clk);
        check("read_pulse", {31'b0, o_read_enable}, 32'd1);
        i_data_valid = 1'b0;
        i_data       = data;
        @(negedge clk);
        check("read_single", {30'b0, o_read_enable, o_data_valid}, 32'd0);
        @(negedge clk);
        check("no_early_dv", {31'b0, o_data_valid}, 32'd0);
        @(negedge clk);
        check("dv_pulse", {31'b0, o_data_valid}, 32'd1);
        check("o_data", {16'b0, o_data}, exp & 32'hFFFF);
        @(negedge clk);
        check("dv_single", {31'b0, o_data_valid}, 32'd0);
    endtask

    // Checks the full CLEAR sweep starting at the negedge where reset has just been released.
    task automatic wait_clear();
        int bad;
        bad = 0;
        for (int i = 0; i < depth; i++) begin
            if (i > 0) @(negedge clk);
            if (o_busy !== 1'b1 || o_read_enable !== 1'b0 || o_data_valid !== 1'b0) bad++;
        end
        check("clear_cycles", bad, 0);
        @(negedge clk);
        check("clear_done_idle", {31'b0, o_busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        i_data_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", {31'b0, o_busy}, 32'd1);
        check("reset_outputs", {14'b0, o_read_enable, o_data_valid, o_data}, 32'd0);
        reset = 1'b0;
        hist.delete();
        wait_clear();
    endtask

    initial begin
        reset = 1'b1; i_data = '0; i_data_valid = 1'b0;
        i_delay = '0; i_gain = '0; i_bypass = 1'b0;
        @(negedge clk);

        // Reset sweep with input valid held low, then bypass back-to-back.
        do_reset();
        run_sample(16'h1234, 4, 8'h80, 1'b1);
        run_sample(16'h1234, 4, 8'h80, 1'b1);
        run_sample(16'hBEEF, 4, 8'h80, 1'b1);

        // Single impulse, delay 4, half gain.
        do_reset();
        run_sample(16'h4000, 4, 8'h80, 1'b0);
        for (int i = 0; i < 11; i++) run_sample(16'h0000, 4, 8'h80, 1'b0);

        // Delay 0 means full depth: echo at sample 16.
        do_reset();
        run_sample(16'h4000, 0, 8'h80, 1'b0);
        for (int i = 0; i < 17; i++) run_sample(16'h0000, 0, 8'h80, 1'b0);

        // Delay 2: feedback decides whether a second echo appears.
        do_reset();
        run_sample(16'h4000, 2, 8'h80, 1'b0);
        for (int i = 0; i < 6; i++) run_sample(16'h0000, 2, 8'h80, 1'b0);

        // Positive and negative saturation.
        do_reset();
        run_sample(16'h7000, 1, 8'hFF, 1'b1);
        run_sample(16'h7000, 1, 8'hFF, 1'b0);
        check("sat_pos_const", {16'b0, o_data}, 32'h7FFF);
        do_reset();
        run_sample(16'h9000, 1, 8'hFF, 1'b1);
        run_sample(16'h9000, 1, 8'hFF, 1'b0);
        check("sat_neg_const", {16'b0, o_data}, 32'h8000);

        // Randomised traffic spanning several wraps of the delay line.
        do_reset();
        for (int i = 0; i < 60; i++)
            run_sample(16'($urandom), $urandom_range(0, 15), $urandom_range(0, 255),
                       ($urandom_range(0, 7) == 0));

        // Reset during MIX abandons the sample; CLEAR must rerun before the next pop.
        i_data_valid = 1'b1; i_delay = 4'd1; i_gain = 8'hFF; i_bypass = 1'b0;
        @(negedge clk);
        check("abort_read", {31'b0, o_read_enable}, 32'd1);
        i_data = 16'h5555;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_no_dv", {31'b0, o_data_valid}, 32'd0);
        reset = 1'b0;
        hist.delete();
        wait_clear();
        run_sample(16'h0000, 1, 8'hFF, 1'b0);
        run_sample(16'h0000, 0, 8'hFF, 1'b0);
        run_sample(16'h0123, 3, 8'hFF, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
